// File: rtl/currency_accum_multi_if.sv
// Bus bundle for the multi-channel credit accumulator: coin inputs, vend/refund
// requests and the credit/change/status outputs. The accumulator uses the slave view.
interface currency_accum_multi_if #(
  parameter int CURRENCY_WIDTH = 7,
  parameter int NUM_CH         = 4
);
  logic [NUM_CH*CURRENCY_WIDTH-1:0] currency_value;
  logic [NUM_CH-1:0]                currency_valid;
  logic                             vend_req;
  logic [CURRENCY_WIDTH-1:0]        vend_price;
  logic                             refund_req;
  logic [CURRENCY_WIDTH-1:0]        total_currency;
  logic                             currency_avail;
  logic [NUM_CH-1:0]                coin_reject;
  logic                             vend_ack;
  logic                             vend_nack;
  logic [CURRENCY_WIDTH-1:0]        change_value;
  logic                             change_valid;
  logic                             refund_done;
  logic                             busy;

  modport master (
    output currency_value, currency_valid, vend_req, vend_price, refund_req,
    input  total_currency, currency_avail, coin_reject, vend_ack, vend_nack,
           change_value, change_valid, refund_done, busy
  );

  modport slave (
    input  currency_value, currency_valid, vend_req, vend_price, refund_req,
    output total_currency, currency_avail, coin_reject, vend_ack, vend_nack,
           change_value, change_valid, refund_done, busy
  );
endinterface

// File: rtl/currency_accum_multi.sv
// Multi-channel credit accumulator with vend/refund FSM and chunked change payout.
// Optional escrow auto-refund after idle timeout is enabled by defining ESCROW_TIMEOUT_EN.
module currency_accum_multi #(
  parameter int CURRENCY_WIDTH = 7,
  parameter int NUM_CH         = 4,
  parameter int MAX_CREDIT     = 127,
  parameter int MAX_CHANGE     = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  rst,
  currency_accum_multi_if.slave bus
);
  localparam int CW = CURRENCY_WIDTH;
  // Wide enough for credit plus every channel at full scale, so the scan never wraps.
  localparam int SW = CW + $clog2(NUM_CH) + 1;
  localparam logic [SW-1:0] MAX_SUM   = SW'(MAX_CREDIT);
  localparam logic [CW-1:0] MAX_CHG_C = CW'(MAX_CHANGE);

  if (MAX_CREDIT > (2**CURRENCY_WIDTH) - 1 || MAX_CHANGE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("currency_accum_multi: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VEND   = 2'd1,
    S_REFUND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [CW-1:0]     price_q, price_d;
  logic [NUM_CH-1:0] valid_prev_q, valid_prev_d;
  logic              vend_prev_q, vend_prev_d;
  logic              refund_prev_q, refund_prev_d;
  logic              avail_q, avail_d;
  logic [NUM_CH-1:0] reject_q, reject_d;
  logic              ack_q, ack_d;
  logic              nack_q, nack_d;
  logic [CW-1:0]     chg_val_q, chg_val_d;
  logic              chg_vld_q, chg_vld_d;
  logic              done_q, done_d;

  logic [NUM_CH-1:0] coin_ev;
  logic              vend_ev;
  logic              refund_ev;
  logic [SW-1:0]     sum;
  logic [CW-1:0]     coin_val;

`ifdef ESCROW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    coin_ev       = bus.currency_valid & ~valid_prev_q;
    vend_ev       = bus.vend_req & ~vend_prev_q;
    refund_ev     = bus.refund_req & ~refund_prev_q;
    valid_prev_d  = bus.currency_valid;
    vend_prev_d   = bus.vend_req;
    refund_prev_d = bus.refund_req;
    state_d       = state_q;
    credit_d      = credit_q;
    price_d       = price_q;
    avail_d       = 1'b0;
    reject_d      = '0;
    ack_d         = 1'b0;
    nack_d        = 1'b0;
    chg_val_d     = '0;
    chg_vld_d     = 1'b0;
    done_d        = 1'b0;
    sum           = SW'(credit_q);
    coin_val      = '0;
`ifdef ESCROW_TIMEOUT_EN
    tmo_d         = '0;
`endif

    case (state_q)
      S_IDLE: begin
        // Lower channel index wins when the remaining headroom is contested.
        for (int i = 0; i < NUM_CH; i++) begin
          coin_val = bus.currency_value[i*CW +: CW];
          if (coin_ev[i]) begin
            if (sum + SW'(coin_val) <= MAX_SUM) begin
              sum     = sum + SW'(coin_val);
              avail_d = 1'b1;
            end else begin
              reject_d[i] = 1'b1;
            end
          end
        end
        credit_d = sum[CW-1:0];
        if (vend_ev) begin
          state_d = S_VEND;
          price_d = bus.vend_price;
        end else if (refund_ev) begin
          state_d = S_REFUND;
        end
`ifdef ESCROW_TIMEOUT_EN
        else if (coin_ev == '0 && credit_q != '0) begin
          if (tmo_q == TMO_LAST) begin
            state_d = S_REFUND;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
`endif
      end
      S_VEND: begin
        reject_d = coin_ev;
        if (credit_q >= price_q) begin
          credit_d = credit_q - price_q;
          ack_d    = 1'b1;
        end else begin
          nack_d   = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_REFUND: begin
        reject_d = coin_ev;
        if (credit_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          chg_val_d = (credit_q > MAX_CHG_C) ? MAX_CHG_C : credit_q;
          chg_vld_d = 1'b1;
          credit_d  = credit_q - chg_val_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      price_q       <= '0;
      valid_prev_q  <= '0;
      vend_prev_q   <= 1'b0;
      refund_prev_q <= 1'b0;
      avail_q       <= 1'b0;
      reject_q      <= '0;
      ack_q         <= 1'b0;
      nack_q        <= 1'b0;
      chg_val_q     <= '0;
      chg_vld_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      price_q       <= price_d;
      valid_prev_q  <= valid_prev_d;
      vend_prev_q   <= vend_prev_d;
      refund_prev_q <= refund_prev_d;
      avail_q       <= avail_d;
      reject_q      <= reject_d;
      ack_q         <= ack_d;
      nack_q        <= nack_d;
      chg_val_q     <= chg_val_d;
      chg_vld_q     <= chg_vld_d;
      done_q        <= done_d;
    end
  end

`ifdef ESCROW_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign bus.total_currency = credit_q;
  assign bus.currency_avail = avail_q;
  assign bus.coin_reject    = reject_q;
  assign bus.vend_ack       = ack_q;
  assign bus.vend_nack      = nack_q;
  assign bus.change_value   = chg_val_q;
  assign bus.change_valid   = chg_vld_q;
  assign bus.refund_done    = done_q;
  assign bus.busy           = (state_q != S_IDLE);
endmodule
